// File: rtl/color_channel_sampler.sv
// TCS3200 front end: steps the colour filter through red, green and blue, counts the
// sensor output frequency in a gated window per filter and classifies the counts as RGBY.
module color_channel_sampler #(
  parameter int WINDOW_CYCLES = 2000,
  parameter int SETTLE_CYCLES = 100,
  parameter int COUNT_W       = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               sensor_freq,
  output logic [1:0]         color_select,
  output logic               busy,
  output logic               done,
  output logic [1:0]         color,
  output logic [COUNT_W-1:0] red_count,
  output logic [COUNT_W-1:0] green_count,
  output logic [COUNT_W-1:0] blue_count,
  output logic               overflow
);

  localparam int TIMER_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = '1;

  // TCS3200 {S2,S3} filter codes
  localparam logic [1:0] SEL_RED   = 2'b00;
  localparam logic [1:0] SEL_GREEN = 2'b11;
  localparam logic [1:0] SEL_BLUE  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_NEXT,
    S_CLASSIFY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_RED,
    CH_GREEN,
    CH_BLUE
  } chan_t;

  state_t               state;
  chan_t                ch;
  logic [TIMER_W-1:0]   timer;
  logic [COUNT_W-1:0]   cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_d;
  logic                 rise;

  logic [COUNT_W-1:0]   hi;
  logic [COUNT_W-1:0]   lo;
  logic [1:0]           color_next;

  // sensor_freq is asynchronous to clk; only the last stage feeds logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_freq};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    hi         = (red_count > green_count) ? red_count : green_count;
    lo         = (red_count > green_count) ? green_count : red_count;
    color_next = 2'd0;
    if ((red_count > blue_count) && (green_count > blue_count) && ((hi - lo) <= (hi >> 2))) begin
      color_next = 2'd3;
    end else if ((red_count >= green_count) && (red_count >= blue_count)) begin
      color_next = 2'd0;
    end else if (green_count >= blue_count) begin
      color_next = 2'd1;
    end else begin
      color_next = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= CH_RED;
      timer        <= '0;
      cnt          <= '0;
      color_select <= SEL_RED;
      busy         <= 1'b0;
      done         <= 1'b0;
      color        <= 2'd0;
      red_count    <= '0;
      green_count  <= '0;
      blue_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_SETTLE;
            ch           <= CH_RED;
            color_select <= SEL_RED;
            timer        <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
          end
        end

        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            timer <= '0;
            cnt   <= '0;
            state <= S_COUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_COUNT: begin
          // Saturate rather than wrap; hitting the ceiling flags the whole run.
          if (rise && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MAX - 1'b1) overflow <= 1'b1;
          end
          if (timer == WINDOW_LAST) begin
            timer <= '0;
            state <= S_NEXT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_NEXT: begin
          case (ch)
            CH_RED: begin
              red_count    <= cnt;
              ch           <= CH_GREEN;
              color_select <= SEL_GREEN;
              state        <= S_SETTLE;
            end
            CH_GREEN: begin
              green_count  <= cnt;
              ch           <= CH_BLUE;
              color_select <= SEL_BLUE;
              state        <= S_SETTLE;
            end
            default: begin
              blue_count <= cnt;
              state      <= S_CLASSIFY;
            end
          endcase
        end

        S_CLASSIFY: begin
          color        <= color_next;
          done         <= 1'b1;
          busy         <= 1'b0;
          color_select <= SEL_RED;
          state        <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_channel_sampler.sv
// Scoreboard bench for color_channel_sampler: a filter-aware sensor model drives the DUT,
// expected results are queued at start and compared when done pulses.
module tb_color_channel_sampler;

  localparam int W       = 20;
  localparam int S       = 4;
  localparam int CW      = 8;
  localparam int SAT_W   = 3;
  localparam int LATENCY = 3 * (S + W + 1) + 2;

  typedef struct {
    int r;
    int g;
    int b;
    int color;
    int ovf;
    int t_start;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset;
  logic          start;
  logic          sensor_freq;
  logic [1:0]    color_select;
  logic          busy;
  logic          done;
  logic [1:0]    color;
  logic [CW-1:0] red_count;
  logic [CW-1:0] green_count;
  logic [CW-1:0] blue_count;
  logic          overflow;

  logic             sat_start;
  logic             sat_freq;
  logic [1:0]       sat_select;
  logic             sat_busy;
  logic             sat_done;
  logic [1:0]       sat_color;
  logic [SAT_W-1:0] sat_red;
  logic [SAT_W-1:0] sat_green;
  logic [SAT_W-1:0] sat_blue;
  logic             sat_overflow;

  color_channel_sampler #(
    .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .COUNT_W(CW), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sensor_freq(sensor_freq),
    .color_select(color_select), .busy(busy), .done(done), .color(color),
    .red_count(red_count), .green_count(green_count), .blue_count(blue_count),
    .overflow(overflow)
  );

  color_channel_sampler #(
    .WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .COUNT_W(SAT_W), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(sat_start), .sensor_freq(sat_freq),
    .color_select(sat_select), .busy(sat_busy), .done(sat_done), .color(sat_color),
    .red_count(sat_red), .green_count(sat_green), .blue_count(sat_blue),
    .overflow(sat_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference classification straight from the colour rules.
  function automatic int classify(input int r, input int g, input int b);
    int hi;
    int lo;
    hi = (r > g) ? r : g;
    lo = (r > g) ? g : r;
    if (r > b && g > b && (hi - lo) <= hi / 4) return 3;
    if (r >= g && r >= b) return 0;
    if (g >= b) return 1;
    return 2;
  endfunction

  function automatic exp_t make_exp(input int n0, input int n1, input int n2,
                                    input int w, input int t0);
    exp_t e;
    int   mx;
    mx = (1 << w) - 1;
    e.r = (n0 > mx) ? mx : n0;
    e.g = (n1 > mx) ? mx : n1;
    e.b = (n2 > mx) ? mx : n2;
    e.ovf = (n0 >= mx || n1 >= mx || n2 >= mx) ? 1 : 0;
    e.color = classify(e.r, e.g, e.b);
    e.t_start = t0;
    return e;
  endfunction

  function automatic int sel_idx(input logic [1:0] s);
    case (s)
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 0;
    endcase
  endfunction

  exp_t sb_q[$];
  exp_t sat_q[$];

  // Sensor model: output depends on the filter the DUT currently selects.
  int   per[3];
  int   burst[3];
  bit   burst_mode;
  int   gen_ph;
  int   gen_chc;
  int   gen_idx;
  logic gen_pb;
  logic [1:0] gen_ps;

  initial begin
    sensor_freq = 1'b0;
    burst_mode  = 1'b0;
    per[0] = 4; per[1] = 4; per[2] = 4;
    burst[0] = 0; burst[1] = 0; burst[2] = 0;
    gen_ph = 0; gen_chc = 0; gen_pb = 1'b0; gen_ps = 2'b00;
    forever begin
      @(negedge clk);
      if ((busy && !gen_pb) || (color_select != gen_ps)) gen_chc = 0;
      else gen_chc++;
      gen_pb  = busy;
      gen_ps  = color_select;
      gen_idx = sel_idx(color_select);
      if (burst_mode) begin
        sensor_freq = (gen_chc >= 8) && (gen_chc < 8 + 2 * burst[gen_idx]) && ((gen_chc - 8) % 2 == 0);
      end else begin
        gen_ph      = (gen_ph + 1) % per[gen_idx];
        sensor_freq = (gen_ph < per[gen_idx] / 2);
      end
    end
  end

  int sat_per;
  int sat_ph;

  initial begin
    sat_freq = 1'b0;
    sat_per  = 2;
    sat_ph   = 0;
    forever begin
      @(negedge clk);
      sat_ph   = (sat_ph + 1) % sat_per;
      sat_freq = (sat_ph < sat_per / 2);
    end
  end

  // Main monitor: filter-select history plus scoreboard compare on done.
  int         done_cnt;
  logic [7:0] sel_log;
  logic       mon_pb;
  logic [1:0] mon_ps;
  exp_t       mon_e;

  initial begin
    done_cnt = 0; sel_log = 8'h00; mon_pb = 1'b0; mon_ps = 2'b00;
    forever begin
      @(negedge clk);
      if (busy && !mon_pb) sel_log = {6'b0, color_select};
      else if (color_select != mon_ps) sel_log = {sel_log[5:0], color_select};
      mon_pb = busy;
      mon_ps = color_select;
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("red_count", int'(red_count), mon_e.r);
          check("green_count", int'(green_count), mon_e.g);
          check("blue_count", int'(blue_count), mon_e.b);
          check("color", int'(color), mon_e.color);
          check("overflow", int'(overflow), mon_e.ovf);
          check("latency", cyc - mon_e.t_start, LATENCY);
          check("busy_at_done", int'(busy), 0);
          check("sel_at_done", int'(color_select), 0);
        end
      end
    end
  end

  exp_t sat_e;

  initial begin
    forever begin
      @(negedge clk);
      if (sat_done) begin
        if (sat_q.size() == 0) begin
          check("sat_unexpected_done", 1, 0);
        end else begin
          sat_e = sat_q.pop_front();
          check("sat_red", int'(sat_red), sat_e.r);
          check("sat_green", int'(sat_green), sat_e.g);
          check("sat_blue", int'(sat_blue), sat_e.b);
          check("sat_color", int'(sat_color), sat_e.color);
          check("sat_overflow", int'(sat_overflow), sat_e.ovf);
          check("sat_latency", cyc - sat_e.t_start, LATENCY);
          check("sat_busy_at_done", int'(sat_busy), 0);
          check("sat_sel_at_done", int'(sat_select), 0);
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic launch_main(input exp_t e);
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_periodic(input int p0, input int p1, input int p2);
    burst_mode = 1'b0;
    per[0] = p0; per[1] = p1; per[2] = p2;
    repeat (3) @(negedge clk);
    launch_main(make_exp(W / p0, W / p1, W / p2, CW, cyc));
    wait_done(LATENCY + 20);
  endtask

  task automatic run_burst(input int n0, input int n1, input int n2);
    burst_mode = 1'b1;
    burst[0] = n0; burst[1] = n1; burst[2] = n2;
    repeat (3) @(negedge clk);
    launch_main(make_exp(n0, n1, n2, CW, cyc));
    wait_done(LATENCY + 20);
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_sel"}, int'(color_select), 0);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_done"}, int'(done), 0);
    check({pfx, "_color"}, int'(color), 0);
    check({pfx, "_red"}, int'(red_count), 0);
    check({pfx, "_green"}, int'(green_count), 0);
    check({pfx, "_blue"}, int'(blue_count), 0);
    check({pfx, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic run_sat(input int p);
    int k;
    sat_per = p;
    repeat (3) @(negedge clk);
    sat_q.push_back(make_exp(W / p, W / p, W / p, SAT_W, cyc));
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    k = 0;
    while (!sat_done && k < LATENCY + 20) begin
      @(negedge clk);
      k++;
    end
    if (!sat_done) check("sat_done_timeout", 0, 1);
  endtask

  int n0;
  int k;
  int busy_drops;

  initial begin
    reset = 1'b1; start = 1'b0; sat_start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cleared("reset");

    // 1: strong red, exact latency.
    run_periodic(2, 10, 10);
    // 2: yellow, with the filter-select sequence.
    run_periodic(4, 4, 20);
    #1;
    check("sel_sequence", int'(sel_log), 8'b00_11_01_00);
    @(negedge clk);
    // 3: ties go to red; a clear green winner.
    run_periodic(4, 4, 4);
    run_burst(3, 6, 3);
    // Yellow tolerance edge: diff 1 == hi>>2 is yellow, diff 2 is not.
    run_burst(5, 4, 1);
    run_burst(6, 4, 1);
    run_burst(2, 2, 5);
    @(negedge clk);

    // 5: start held high through a whole run, including the DONE cycle.
    burst_mode = 1'b0;
    per[0] = 4; per[1] = 4; per[2] = 4;
    repeat (3) @(negedge clk);
    #1;
    n0 = done_cnt;
    sb_q.push_back(make_exp(5, 5, 5, CW, cyc));
    start = 1'b1;
    @(negedge clk);
    busy_drops = 0;
    k = 0;
    while (!done && k < LATENCY + 20) begin
      if (!busy) busy_drops++;
      @(negedge clk);
      k++;
    end
    if (!done) check("done_timeout", 0, 1);
    check("busy_mid_run_drops", busy_drops, 0);
    @(negedge clk);
    check("start_in_done_ignored", int'(busy), 0);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("single_done", done_cnt - n0, 1);

    // Restart in the cycle right after done.
    run_periodic(4, 4, 20);
    start = 1'b1;
    sb_q.push_back(make_exp(5, 5, 1, CW, cyc + 1));
    @(negedge clk);
    check("idle_after_done_busy", int'(busy), 0);
    @(negedge clk);
    check("restart_busy", int'(busy), 1);
    start = 1'b0;
    wait_done(LATENCY + 20);
    @(negedge clk);

    // 6: reset in the green counting window.
    burst_mode = 1'b0;
    per[0] = 2; per[1] = 10; per[2] = 10;
    repeat (3) @(negedge clk);
    sb_q.push_back(make_exp(10, 2, 2, CW, cyc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (38) @(negedge clk);
    check("pre_reset_sel_green", int'(color_select), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("midrun_reset");
    sb_q.delete();
    #1;
    n0 = done_cnt;
    repeat (LATENCY + 10) @(negedge clk);
    #1;
    check("no_done_after_reset", done_cnt - n0, 0);
    run_periodic(2, 10, 10);

    // 4: narrow counters saturate, then the flag clears on a clean run.
    run_sat(2);
    @(negedge clk);
    run_sat(10);
    repeat (3) @(negedge clk);

    #1;
    check("sb_empty", sb_q.size(), 0);
    check("sat_sb_empty", sat_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
